// File: rtl/ijtag_scan_host_pkg.sv
// ijtag_scan_host_pkg
//   Shared definitions for the IJTAG scan host:
//   - DEFAULT_MAX_LEN : default maximum shift length / data vector width
//   - LEN_MASK_W      : widest vector len_mask() can describe
//   - state_e         : scan pass states (IDLE, CAPTURE, SHIFT, UPDATE, RESP)
//   - len_mask(len)   : vector with bits [len-1:0] set, bits above cleared
//   The optional response compare (IJTAG_SCAN_HOST_COMPARE_EN) uses len_mask.
package ijtag_scan_host_pkg;

  localparam int DEFAULT_MAX_LEN = 64;
  localparam int LEN_MASK_W      = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RESP    = 3'd4
  } state_e;

  // Callers cast the result down to their own vector width.
  function automatic logic [LEN_MASK_W-1:0] len_mask(input int unsigned len);
    logic [LEN_MASK_W-1:0] m;
    for (int unsigned i = 0; i < LEN_MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/ijtag_scan_host_if.sv
// ijtag_scan_host_if
//   Request/response bus between a requester (test controller or firmware
//   mailbox) and the IJTAG scan host.
//   req_valid/req_ready/req_len/req_data : scan request handshake
//   rsp_valid/rsp_ready/rsp_data         : shifted-out response handshake
//   With IJTAG_SCAN_HOST_COMPARE_EN defined, also req_exp/req_mask (expected
//   value and compare mask, latched with the request) and rsp_fail.
//   modport master : requester side
//   modport slave  : scan host side
interface ijtag_scan_host_if
  import ijtag_scan_host_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);

  logic               req_valid;
  logic               req_ready;
  logic [LEN_W-1:0]   req_len;
  logic [MAX_LEN-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
`ifdef IJTAG_SCAN_HOST_COMPARE_EN
  logic [MAX_LEN-1:0] req_exp;
  logic [MAX_LEN-1:0] req_mask;
  logic               rsp_fail;
`endif

  modport master (
    output req_valid, req_len, req_data, rsp_ready,
`ifdef IJTAG_SCAN_HOST_COMPARE_EN
    output req_exp, req_mask,
    input  rsp_fail,
`endif
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_len, req_data, rsp_ready,
`ifdef IJTAG_SCAN_HOST_COMPARE_EN
    input  req_exp, req_mask,
    output rsp_fail,
`endif
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ijtag_scan_host_shreg.sv
// ijtag_scan_host_shreg
//   Datapath of the scan host: shift-in register, capture register, bit
//   counter and the registered scan-out (si) bit.
//   clk, srst : clock, synchronous active-high reset
//   load      : request accepted this cycle (latch req_data, clear capture)
//   shift     : current cycle is a shift cycle (sample so, advance counter)
//   se_next   : next cycle is a shift cycle (present its bit on si)
//   req_data  : shift-in vector, bit 0 first
//   so        : scan data returning from the network
//   si        : registered scan data to the network, 0 outside shift cycles
//   cap       : captured so bits, bit k from shift cycle k
//   cnt       : index of the current shift cycle
module ijtag_scan_host_shreg
  import ijtag_scan_host_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  input  logic               shift,
  input  logic               se_next,
  input  logic [MAX_LEN-1:0] req_data,
  input  logic               so,
  output logic               si,
  output logic [MAX_LEN-1:0] cap,
  output logic [LEN_W-1:0]   cnt
);

  logic [MAX_LEN-1:0] data_q, data_d, data_shr;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               si_q, si_d;

  // data_q is consumed from bit 0, so the bit for the next shift cycle is
  // data_q[0] when starting and the post-shift bit 0 while already shifting.
  assign data_shr = data_q >> 1;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = req_data;
      cnt_d  = '0;
    end else if (shift) begin
      data_d = data_shr;
      cnt_d  = cnt_q + 1'b1;
    end
    si_d = 1'b0;
    if (se_next) begin
      si_d = shift ? data_shr[0] : data_q[0];
    end
  end

  // Each capture bit only listens to so on its own shift cycle.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cap
    assign cap_d[gi] = load ? 1'b0 :
                       (shift && (cnt_q == LEN_W'(gi))) ? so : cap_q[gi];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      data_q <= '0;
      cap_q  <= '0;
      cnt_q  <= '0;
      si_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      cap_q  <= cap_d;
      cnt_q  <= cnt_d;
      si_q   <= si_d;
    end
  end

  assign si  = si_q;
  assign cap = cap_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/ijtag_scan_host.sv
// ijtag_scan_host
//   IJTAG initiator: accepts a scan request and runs one capture-shift-update
//   pass over the attached SIB/TDR network, then returns the shifted-out bits.
//   ijtag_tck, ijtag_reset : clock, synchronous active-high reset
//   bus (slave)            : request/response handshake (ijtag_scan_host_if)
//   ijtag_sel/ce/se/ue/si  : registered network controls and scan-in data
//   ijtag_so               : scan-out from the network (falling-edge retimed)
//   Optional: IJTAG_SCAN_HOST_COMPARE_EN adds masked expected-value compare
//   producing bus.rsp_fail alongside the response.
module ijtag_scan_host
  import ijtag_scan_host_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  ijtag_scan_host_if.slave   bus,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_CAPTURE = CAPTURE;
  localparam logic [2:0] ST_SHIFT   = SHIFT;
  localparam logic [2:0] ST_UPDATE  = UPDATE;
  localparam logic [2:0] ST_RESP    = RESP;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sel_q, sel_d, ce_q, ce_d, se_q, se_d, ue_q, ue_d;
  logic               req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic               accept, shifting;
  logic [LEN_W-1:0]   cnt;
  logic [MAX_LEN-1:0] cap;
  logic               si;

  assign accept   = (state_q == ST_IDLE) && bus.req_valid;
  assign shifting = (state_q == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = ST_CAPTURE;
          len_d   = (bus.req_len > MAX_LEN_L) ? MAX_LEN_L : bus.req_len;
        end
      end
      ST_CAPTURE: state_d = (len_q == '0) ? ST_UPDATE : ST_SHIFT;
      ST_SHIFT:   if (cnt == len_q - 1'b1) state_d = ST_UPDATE;
      ST_UPDATE:  state_d = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one is
  // a clean flop that is valid for the whole cycle of the state it marks.
  always_comb begin
    sel_d       = (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) ||
                  (state_d == ST_UPDATE);
    ce_d        = (state_d == ST_CAPTURE);
    se_d        = (state_d == ST_SHIFT);
    ue_d        = (state_d == ST_UPDATE);
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      sel_q       <= 1'b0;
      ce_q        <= 1'b0;
      se_q        <= 1'b0;
      ue_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sel_q       <= sel_d;
      ce_q        <= ce_d;
      se_q        <= se_d;
      ue_q        <= ue_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  ijtag_scan_host_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clk      (ijtag_tck),
    .srst     (ijtag_reset),
    .load     (accept),
    .shift    (shifting),
    .se_next  (state_d == ST_SHIFT),
    .req_data (bus.req_data),
    .so       (ijtag_so),
    .si       (si),
    .cap      (cap),
    .cnt      (cnt)
  );

`ifdef IJTAG_SCAN_HOST_COMPARE_EN
  logic [MAX_LEN-1:0] exp_q, exp_d, mask_q, mask_d, lenmask;
  logic               rsp_fail_q, rsp_fail_d;

  // The capture register is complete during UPDATE, so the verdict is
  // formed there and lands together with rsp_valid.
  always_comb begin
    lenmask    = MAX_LEN'(len_mask(32'(len_q)));
    exp_d      = exp_q;
    mask_d     = mask_q;
    rsp_fail_d = rsp_fail_q;
    if (accept) begin
      exp_d      = bus.req_exp;
      mask_d     = bus.req_mask;
      rsp_fail_d = 1'b0;
    end else if (state_q == ST_UPDATE) begin
      rsp_fail_d = |((cap ^ exp_q) & mask_q & lenmask);
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      exp_q      <= '0;
      mask_q     <= '0;
      rsp_fail_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      rsp_fail_q <= rsp_fail_d;
    end
  end

  assign bus.rsp_fail = rsp_fail_q;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = cap;
  assign ijtag_sel     = sel_q;
  assign ijtag_ce      = ce_q;
  assign ijtag_se      = se_q;
  assign ijtag_ue      = ue_q;
  assign ijtag_si      = si;

endmodule

// File: doc/ijtag_scan_host.md
Name: ijtag_scan_host

Overview:
- IJTAG initiator that drives one IJTAG scan network: SIB chain plus TDR segments hanging off sel/ce/se/ue/si/so.
- Accepts a scan request (length, shift-in vector), then runs one capture-shift-update pass and returns the shifted-out vector.
- Sits between the gate-level test controller or firmware mailbox and the SIB network root. It is the driving end of the interface the network's SIBs receive.

Parameters:
- MAX_LEN, 64, maximum shift length in bits; width of the data vectors.
- LEN_W, $clog2(MAX_LEN+1), width of req_len.

Ports:
- ijtag_tck  input  1  single clock; all logic on posedge.
- ijtag_reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request valid.
- req_ready  output  1  host idle and able to accept.
- req_len  input  LEN_W  shift length in bits; 0 is legal.
- req_data  input  MAX_LEN  shift-in vector; bit 0 is shifted first.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted.
- rsp_data  output  MAX_LEN  shifted-out vector; bit k is the so value sampled on shift cycle k; bits >= len are 0.
- ijtag_sel  output  1  network select.
- ijtag_ce  output  1  capture enable.
- ijtag_se  output  1  shift enable.
- ijtag_ue  output  1  update enable.
- ijtag_si  output  1  scan data to the network.
- ijtag_so  input  1  scan data from the network; already retimed on the falling edge by the last SIB.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All ijtag_* outputs are 0, req_ready=1, rsp_valid=0, rsp_data=0.
  - Reset mid-operation aborts the pass with no update cycle; any pending response is dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
  - IDLE:
    - req_ready=1.
    - On req_valid, latch req_data and len = min(req_len, MAX_LEN), clear the capture register, then go to CAPTURE.
  - CAPTURE:
    - Exactly 1 cycle with sel=1, ce=1.
    - Next state is SHIFT if len>0, otherwise UPDATE.
  - SHIFT:
    - Exactly len cycles with sel=1, se=1, si=data[k] on cycle k.
    - At the posedge ending cycle k, capture ijtag_so into rsp_data[k].
    - A bit counter counts 0..len-1; it wraps to UPDATE after len-1.
  - UPDATE:
    - Exactly 1 cycle with sel=1, ue=1, so the SIB falling-edge latch sees ue & sel.
    - Then go to RESP.
  - RESP:
    - sel=0 and all enables 0; rsp_valid=1.
    - rsp_data is held stable until rsp_ready.
    - The handshake completes on rsp_valid & rsp_ready; return to IDLE.
- ce, se and ue are mutually exclusive in every cycle.
- si=0 whenever se=0.
- sel drops for at least 1 cycle between passes: RESP and IDLE both drive sel=0.
- Total latency from request accept to rsp_valid is len+3 cycles (capture, len shifts, update, then RESP registered).
- req_len > MAX_LEN clamps to MAX_LEN.
- req_valid asserted while not in IDLE is ignored, because req_ready=0.

Optional Feature:
- Macro: IJTAG_SCAN_HOST_COMPARE_EN.
- When defined:
  - Extra inputs req_exp[MAX_LEN] and req_mask[MAX_LEN] are latched with the request.
  - Extra output rsp_fail = |((rsp_data ^ exp) & mask & lenmask), where lenmask covers bits below len.
  - rsp_fail is registered and valid with rsp_valid; it is 0 at reset.
- When undefined: these ports and that logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package ijtag_scan_host_pkg holds:
  - state enum (IDLE, CAPTURE, SHIFT, UPDATE, RESP);
  - default MAX_LEN;
  - helper function len_mask(len).
- One natural sub-module, ijtag_scan_host_shreg: holds the shift-in/capture registers, bit counter and si mux. The FSM stays in the top module.

Test Plan:
- Network model: N-bit shift register with so = last stage. req_len=8, req_data=0xA5, model preloaded 0x3C:
  - expect rsp_data=0x3C after 8 shifts;
  - model holds 0xA5 after UPDATE;
  - ce=1 for exactly 1 cycle before the first se;
  - ue=1 for exactly 1 cycle after the last se.
- req_len=0: CAPTURE then UPDATE with no se cycles; rsp_data=0; rsp_valid 3 cycles after accept.
- req_len=MAX_LEN+5 with MAX_LEN=64: exactly 64 se cycles; full 64-bit round trip matches the model.
- Response backpressure:
  - hold rsp_ready=0 for 10 cycles: rsp_valid and rsp_data stable, req_ready=0, second req_valid ignored;
  - release: handshake completes, the next request is accepted and sel stays low for at least 1 cycle in between.
- Assert ijtag_reset during SHIFT cycle 3 of a 16-bit pass:
  - next cycle all ijtag_* outputs are 0, with no ue pulse;
  - rsp_valid=0, req_ready=1.
- Compare check with IJTAG_SCAN_HOST_COMPARE_EN defined and len=8:
  - exp=0x3C, mask=0xFF, model 0x3C: rsp_fail=0;
  - model 0x3D: rsp_fail=1;
  - mask=0xFE with model 0x3D: rsp_fail=0.
